// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam int SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_fs_bit_cell.sv
// Single-bit full-subtractor cell: d = x - y - bi, bo = borrow out.
module fs_bit_cell
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, start/busy/done handshake.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] sa_q, sb_q, sa_d, sb_d;
  logic             borrow_q;
  logic             busy_q, done_q, bout_q;
  logic [WIDTH-1:0] diff_q;
  logic             cell_d, cell_bo;

  fs_bit_cell u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Result bits enter sa from the MSB as operand bits leave at the LSB,
  // so after WIDTH shifts sa_d holds the complete difference.
  assign sa_d = {cell_d, sa_q[WIDTH-1:1]};
  assign sb_d = {1'b0, sb_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sa_q     <= a;
            sb_q     <= b;
            borrow_q <= bin;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a[WIDTH-1];
            b_msb_q  <= b[WIDTH-1];
`endif
          end
        end
        S_SHIFT: begin
          sa_q     <= sa_d;
          sb_q     <= sb_d;
          borrow_q <= cell_bo;
          if (count_q == LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            diff_q  <= sa_d;
            bout_q  <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
`endif
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes model results, monitor pops on done.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    int unsigned  issue;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int unsigned n_total = 0, n_pass = 0;
  int unsigned cyc = 0, done_cnt = 0, issued = 0;
  exp_t        sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: (W+1)-bit unsigned subtraction; the top bit is the final borrow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    logic [W:0] full;
    full  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.d   = full[W-1:0];
    e.bo  = full[W];
    e.ov  = (x[W-1] ^ y[W-1]) & (x[W-1] ^ full[W-1]);
    e.issue = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("borrow_out", 32'(borrow_out), 32'(e.bo));
        chk("latency", cyc - e.issue, W + 1);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ov));
`endif
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    wait_idle();
    a = x; b = y; bin = bi; start = 1'b1;
    e = model(x, y, bi);
    e.issue = cyc;
    sb.push_back(e);
    issued++;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
  endtask

  initial begin
    int unsigned dc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_borrow", 32'(borrow_out), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    start_op(8'd100, 8'd37, 1'b0);
    wait_idle();
    chk("t1_done_low_after", 32'(done), 32'(0));
    chk("t1_diff_held", 32'(diff), 32'(63));
    start_op(8'd5, 8'd9, 1'b0);
    start_op(8'd0, 8'd0, 1'b1);
    start_op(8'hFF, 8'hFF, 1'b0);
    start_op(8'h80, 8'h01, 1'b0);
    start_op(8'h10, 8'h01, 1'b0);

    // Start while busy is ignored: a second start at k+3
    wait_idle();
    dc = done_cnt;
    start_op(8'd100, 8'd37, 1'b0);
    @(posedge clk); #1;
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("single_done_pulse", done_cnt - dc, 1);
    chk("ignored_diff", 32'(diff), 32'(63));

    // Reset mid-operation discards the result
    start_op(8'd200, 8'd13, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    issued--;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_diff", 32'(diff), 32'(0));
    chk("midrst_borrow", 32'(borrow_out), 32'(0));
    rst_n = 1'b1;
    dc = done_cnt;
    repeat (W + 4) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - dc, 0);
    start_op(8'd42, 8'd50, 1'b0);

    // Randomized operations
    for (int i = 0; i < 30; i++)
      start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", done_cnt, issued);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
